// File: rtl/multicycle_main_controller_pkg.sv
// Shared definitions for the multi-cycle main controller: opcodes, FSM states,
// ALU select encodings and the opcode class bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // {Alu1, Alu0}
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Instruction/data memory handshake and datapath control bundle of the
// multi-cycle main controller.
interface multicycle_main_controller_if #(
  parameter int unsigned OPCODE_W = 7
);
  logic [OPCODE_W-1:0] Opcode;
  logic instr_valid;
  logic mem_ready;
  logic trap_clr;

  logic fetch_req;
  logic IRWrite;
  logic PCWrite;
  logic RegWrite;
  logic MemWrite;
  logic MemRead;
  logic Branch;
  logic ALUSrc;
  logic Alu0;
  logic Alu1;
  logic jump;
  logic trap;
  logic trap_cause;

  modport slave (
    input  Opcode, instr_valid, mem_ready, trap_clr,
    output fetch_req, IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Branch, ALUSrc,
           Alu0, Alu1, jump, trap, trap_cause
  );

  modport master (
    output Opcode, instr_valid, mem_ready, trap_clr,
    input  fetch_req, IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Branch, ALUSrc,
           Alu0, Alu1, jump, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_main_controller_decode.sv
// Pure combinational opcode classifier: one-hot class bits plus an illegal flag.
module opcode_class_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] op_i,
  output op_class_t           class_o
);

  logic hi_zero;

  // Bits above the 7-bit opcode field must be zero for a legal opcode.
  if (OPCODE_W > 7) begin : g_hi
    assign hi_zero = ~|op_i[OPCODE_W-1:7];
  end else begin : g_no_hi
    assign hi_zero = 1'b1;
  end

  always_comb begin
    class_o = '0;
    if (!hi_zero) begin
      class_o.illegal = 1'b1;
    end else begin
      case (op_i[6:0])
        OP_R:      class_o.r       = 1'b1;
        OP_I:      class_o.i       = 1'b1;
        OP_LOAD:   class_o.load    = 1'b1;
        OP_STORE:  class_o.store   = 1'b1;
        OP_BRANCH: class_o.branch  = 1'b1;
        OP_JAL:    class_o.jal     = 1'b1;
        default:   class_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with ready
// handshakes, a MEM wait timeout and a sticky trap state.
module multicycle_main_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 7,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                          clk,
  input logic                          reset,
  multicycle_main_controller_if.slave  bus
);

  localparam int unsigned    CntW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = (MEM_TIMEOUT > 0) ? CntW'(MEM_TIMEOUT - 1) : '0;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                cause_q, cause_d;
  op_class_t           cls;

  opcode_class_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .op_i    (op_q),
    .class_o (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          op_d    = bus.Opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls.illegal) begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.r || cls.i) begin
          state_d = S_WB;
        end else if (cls.load || cls.store) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // A completing access wins over a timeout reached in the same cycle.
        if (bus.mem_ready) begin
          state_d = cls.load ? S_WB : S_FETCH;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CntLimit)) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_WB: state_d = S_FETCH;
      S_TRAP: begin
        if (bus.trap_clr) begin
          state_d = S_FETCH;
          cause_d = 1'b0;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.fetch_req  = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.Branch     = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.Alu0       = 1'b0;
    bus.Alu1       = 1'b0;
    bus.jump       = 1'b0;
    bus.trap       = 1'b0;
    bus.trap_cause = cause_q;
    unique case (state_q)
      S_FETCH: begin
        bus.fetch_req = 1'b1;
        bus.IRWrite   = bus.instr_valid & ~reset;
        bus.PCWrite   = bus.instr_valid & ~reset;
      end
      S_EXEC: begin
        if (cls.r || cls.i)  {bus.Alu1, bus.Alu0} = ALU_FUNCT;
        else if (cls.branch) {bus.Alu1, bus.Alu0} = ALU_BRANCH;
        else                 {bus.Alu1, bus.Alu0} = ALU_ADD;
        bus.ALUSrc   = cls.i | cls.load | cls.store;
        bus.Branch   = cls.branch;
        bus.jump     = cls.jal;
        bus.RegWrite = cls.jal;
      end
      S_MEM: begin
        bus.MemRead  = cls.load;
        bus.MemWrite = cls.store;
        bus.ALUSrc   = 1'b1;
      end
      S_WB:    bus.RegWrite = 1'b1;
      S_TRAP:  bus.trap     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed self-checking bench: per-cycle expected control vectors for each
// instruction class, timeout, illegal opcode and reset scenarios.
module tb_multicycle_main_controller;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_main_controller_if #(.OPCODE_W(7)) bus ();

  multicycle_main_controller #(
    .OPCODE_W    (7),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {fetch_req, IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Branch, ALUSrc,
  //  Alu1, Alu0, jump, trap, trap_cause}
  wire [12:0] outs = {bus.fetch_req, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                      bus.MemRead, bus.Branch, bus.ALUSrc, bus.Alu1, bus.Alu0, bus.jump,
                      bus.trap, bus.trap_cause};

  localparam logic [12:0] V_FETCH    = 13'h1000;
  localparam logic [12:0] V_FETCH_IV = 13'h1C00;
  localparam logic [12:0] V_NONE     = 13'h0000;
  localparam logic [12:0] V_EXEC_R   = 13'h0010;
  localparam logic [12:0] V_EXEC_I   = 13'h0030;
  localparam logic [12:0] V_EXEC_LS  = 13'h0020;
  localparam logic [12:0] V_EXEC_BR  = 13'h0048;
  localparam logic [12:0] V_EXEC_JAL = 13'h0204;
  localparam logic [12:0] V_WB       = 13'h0200;
  localparam logic [12:0] V_MEM_LD   = 13'h00A0;
  localparam logic [12:0] V_MEM_ST   = 13'h0120;
  localparam logic [12:0] V_TRAP_ILL = 13'h0002;
  localparam logic [12:0] V_TRAP_TO  = 13'h0003;

  int errors = 0;
  int checks = 0;

  task automatic drive(input logic iv, input logic [6:0] op, input logic mr, input logic clr);
    bus.instr_valid = iv;
    bus.Opcode      = op;
    bus.mem_ready   = mr;
    bus.trap_clr    = clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, OP_R, 1'b0, 1'b0);
    #12;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", outs, V_FETCH);
    end
    drive(1'b1, OP_R, 1'b1, 1'b1);
    #1;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_inputs_ignored got=%h want=%h", outs, V_FETCH);
    end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, OP_R, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", outs, V_FETCH);
    end
    next_cycle();
  endtask

  // Single instruction with no MEM phase: instr_valid only at cycle 0.
  task automatic test_simple(input string name, input logic [6:0] op,
                             input logic [12:0] ex, input logic has_wb);
    logic [12:0] want [5];
    int n;
    want = '{V_FETCH_IV, V_NONE, ex, has_wb ? V_WB : V_FETCH, V_FETCH};
    n = has_wb ? 5 : 4;
    for (int c = 0; c < n; c++) begin
      drive(c == 0, op, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h want=%h", name, c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    logic [12:0] want [8];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_LS, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB, V_FETCH};
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, OP_LOAD, c == 5, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL load cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_store_timeout();
    logic [12:0] want [11];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_LS, V_MEM_ST, V_MEM_ST, V_MEM_ST, V_MEM_ST,
             V_TRAP_TO, V_TRAP_TO, V_TRAP_TO, V_FETCH};
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, OP_STORE, 1'b0, c == 9);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL store_timeout cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_store_ready_at_limit();
    logic [12:0] want [8];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_LS, V_MEM_ST, V_MEM_ST, V_MEM_ST, V_MEM_ST, V_FETCH};
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, OP_STORE, c == 6, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL store_at_limit cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  // trap_clr is also pulsed in DECODE, where it must be ignored.
  task automatic test_illegal();
    logic [12:0] want [6];
    want = '{V_FETCH_IV, V_NONE, V_TRAP_ILL, V_TRAP_ILL, V_TRAP_ILL, V_FETCH};
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 7'b1111111, 1'b1, (c == 1) || (c == 4));
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL illegal cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  // Live Opcode switches to STORE after fetch; instr_valid and mem_ready held
  // high outside their states.
  task automatic test_opcode_change();
    logic [12:0] want [5];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_R, V_WB, V_FETCH};
    for (int c = 0; c < 5; c++) begin
      drive(c < 4, (c == 0) ? OP_R : OP_STORE, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL opcode_change cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] want [8];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_R, V_WB, V_FETCH_IV, V_NONE, V_EXEC_JAL, V_FETCH};
    for (int c = 0; c < 8; c++) begin
      drive((c == 0) || (c == 4), (c < 4) ? OP_R : OP_JAL, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_load();
    logic [12:0] want [4];
    want = '{V_FETCH_IV, V_NONE, V_EXEC_LS, V_MEM_LD};
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, OP_LOAD, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== want[c]) begin
        errors++;
        $display("FAIL reset_mid_load cyc%0d got=%h want=%h", c, outs, want[c]);
      end
      if (c < 3) next_cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_async_drop got=%h want=%h", outs, V_FETCH);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_after_release got=%h want=%h", outs, V_FETCH);
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_simple("rtype", OP_R, V_EXEC_R, 1'b1);
    test_simple("ialu", OP_I, V_EXEC_I, 1'b1);
    test_simple("branch", OP_BRANCH, V_EXEC_BR, 1'b0);
    test_simple("jal", OP_JAL, V_EXEC_JAL, 1'b0);
    test_load();
    test_store_timeout();
    test_store_ready_at_limit();
    test_illegal();
    test_opcode_change();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
